solver_sequencer: RTL

- Control front-end for the division-table solver pipeline.
- Walks the divisions ROM from address 0 to ENTRY_COUNT-1 and issues one entry per cycle into the pipeline under a valid/ready handshake.
- Counts work in flight, accumulates the per-entry results returned by the last pipeline stage into a 64-bit total, and raises done once every issued entry has drained.
- Sits between the ROM and stage 1 of the pipeline, and owns total_sum and done for the solver top level.

---
 rtl/solver_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/solver_sequencer.sv
// Sequencer for the division-table solver: streams ROM entries into the pipeline,
// tracks in-flight work and accumulates results. Optional: SOLVER_SEQ_OVERFLOW_DETECT_EN.
module solver_sequencer #(
  parameter int ENTRY_COUNT = 468,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 64,
  parameter int INFLIGHT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd_en,
  output logic              issue_valid,
  input  logic              issue_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] total_sum,
  output logic [15:0]       contrib_count,
  output logic              busy,
  output logic              done,
  output logic              proto_err,
  output logic              overflow
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ENTRY_COUNT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_next;
  logic [CNT_W-1:0]      r_issued;
  logic                  r_issue_valid;
  logic [INFLIGHT_W-1:0] r_inflight;
  logic [DATA_W-1:0]     r_sum;
  logic [15:0]           r_count;
  logic                  r_proto_err;
  logic                  w_rd_en, w_hs, w_last_hs, w_enter_run, w_idle_res;
  logic [DATA_W-1:0]     w_sum_nxt;

  // At most one read is outstanding, so once every read has been issued the
  // entry sitting in the output register is the last one.
  assign w_rd_en     = (r_state == S_RUN) && (r_issued < LAST) && (!r_issue_valid || issue_ready);
  assign w_hs        = r_issue_valid && issue_ready;
  assign w_last_hs   = (r_state == S_RUN) && w_hs && (r_issued == LAST);
  assign w_enter_run = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_idle_res  = (r_inflight == '0) || (r_state == S_IDLE) || (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last_hs) w_next = S_DRAIN;
      S_DRAIN: if (r_inflight == '0) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued      <= '0;
      r_issue_valid <= 1'b0;
    end else begin
      if (w_enter_run)  r_issued <= '0;
      else if (w_rd_en) r_issued <= r_issued + 1'b1;
      if (w_rd_en)          r_issue_valid <= 1'b1;
      else if (issue_ready) r_issue_valid <= 1'b0;
    end
  end

  // Simultaneous issue and retire cancel; a stray result never drives it negative.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
    end else if (w_hs && !res_valid) begin
      r_inflight <= r_inflight + 1'b1;
    end else if (!w_hs && res_valid && (r_inflight != '0)) begin
      r_inflight <= r_inflight - 1'b1;
    end
  end

`ifdef SOLVER_SEQ_OVERFLOW_DETECT_EN
  logic [DATA_W:0] w_add_full;
  logic            r_overflow;
  assign w_add_full = {1'b0, r_sum} + {1'b0, res_data};
  assign w_sum_nxt  = w_add_full[DATA_W-1:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_overflow <= 1'b0;
    else if (w_enter_run)                  r_overflow <= 1'b0;
    else if (res_valid && w_add_full[DATA_W]) r_overflow <= 1'b1;
  end
  assign overflow = r_overflow;
`else
  assign w_sum_nxt = r_sum + res_data;
  assign overflow  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else if (w_enter_run) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_proto_err <= 1'b0;
    end else if (res_valid) begin
      r_sum   <= w_sum_nxt;
      r_count <= r_count + 16'd1;
      if (w_idle_res) r_proto_err <= 1'b1;
    end
  end

  assign rom_addr      = r_issued[ADDR_W-1:0];
  assign rom_rd_en     = w_rd_en;
  assign issue_valid   = r_issue_valid;
  assign total_sum     = r_sum;
  assign contrib_count = r_count;
  assign busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done          = (r_state == S_DONE);
  assign proto_err     = r_proto_err;

endmodule
